// File: rtl/hd_program_loader_pkg.sv
// -----------------------------------------------------------------------------
// hd_program_loader_pkg
// Shared definitions for the HD program loader and its process table:
//   - FSM state encoding
//   - error codes reported on err_code
//   - process-table entry layout
//   - default instruction-memory depth, shared with the instruction memory
// -----------------------------------------------------------------------------
package hd_program_loader_pkg;

    localparam int MEM_DEPTH_DEF = 201;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_FINISH = 3'd5,
        ST_FAIL   = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_ZERO = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [31:0] base;
        logic [15:0] len;
    } proc_entry_t;

endpackage

// File: rtl/hd_program_loader_proc_table.sv
// -----------------------------------------------------------------------------
// hd_program_loader_proc_table
// Per-process table of {valid, base, len}: one synchronous write port, one
// combinational read port, synchronous bulk clear and asynchronous reset.
// Ports:
//   clock, reset     clock and asynchronous active-low reset
//   clr_i            invalidate and zero every entry (wins over a write)
//   wr_en_i          write wr_entry_i into entry wr_idx_i
//   rd_idx_i         read index; rd_entry_o follows it combinationally
// -----------------------------------------------------------------------------
module hd_program_loader_proc_table
    import hd_program_loader_pkg::*;
#(
    parameter int MAX_PROCS = 8,
    parameter int PROC_W    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [PROC_W-1:0] wr_idx_i,
    input  proc_entry_t       wr_entry_i,
    input  logic [PROC_W-1:0] rd_idx_i,
    output proc_entry_t       rd_entry_o
);

    proc_entry_t entries_q [MAX_PROCS];

    // NOTE: this small table is reset entry by entry because the scheduler
    // relies on valid=0 after reset; a large RAM would not be reset this way.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_PROCS; i++) entries_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < MAX_PROCS; i++) entries_q[i] <= '0;
        end else if (wr_en_i) begin
            entries_q[wr_idx_i] <= wr_entry_i;
        end
    end

    assign rd_entry_o = entries_q[rd_idx_i];

endmodule

// File: rtl/hd_program_loader.sv
// -----------------------------------------------------------------------------
// hd_program_loader
// Copies a block of words from the HD into the next free instruction-memory
// slot using an explicit request/valid handshake, and records the placement
// of each process's program in a process table.
// Ports:
//   clock, reset               clock and asynchronous active-low reset
//   start_load, proc_id,       load request and its parameters (IDLE only)
//   hd_base, prog_len
//   clear_all                  in IDLE: cursor to 0, table invalidated
//   busy, done, error,         status; done/error are one-cycle pulses,
//   err_code                   err_code holds until the next accepted start
//   hd_addr, hd_rd_en,         HD read side
//   hd_data, hd_valid
//   mem_wr_en, mem_wr_addr,    instruction-memory write port
//   mem_wr_data
//   free_cursor                next free instruction-memory address
//   sel_id, proc_valid,        combinational process-table read
//   proc_base, proc_len
// All control outputs are registered; address/data outputs read 0 while
// their strobe is low.
// -----------------------------------------------------------------------------
module hd_program_loader
    import hd_program_loader_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int MAX_PROCS = 8,
    parameter int PROC_W    = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_load,
    input  logic [PROC_W-1:0] proc_id,
    input  logic [31:0]       hd_base,
    input  logic [15:0]       prog_len,
    input  logic              clear_all,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [31:0]       hd_addr,
    output logic              hd_rd_en,
    input  logic [31:0]       hd_data,
    input  logic              hd_valid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [31:0]       free_cursor,
    input  logic [PROC_W-1:0] sel_id,
    output logic              proc_valid,
    output logic [31:0]       proc_base,
    output logic [15:0]       proc_len
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [31:0]       cursor_q, cursor_d;
    logic [15:0]       count_q, count_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [PROC_W-1:0] pid_q, pid_d;
    logic [31:0]       base_q, base_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              hd_rd_en_q, hd_rd_en_d;
    logic [31:0]       hd_addr_q, hd_addr_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [31:0]       mem_wr_addr_q, mem_wr_addr_d;
    logic [31:0]       mem_wr_data_q, mem_wr_data_d;

    logic              tbl_clr, tbl_wr;
    proc_entry_t       tbl_wr_entry, tbl_rd_entry;
    logic              len_ovf;

    // 33-bit sum so a huge prog_len near the top of the address space cannot
    // wrap around and pass the bound check.
    assign len_ovf = ({1'b0, cursor_q} + {17'b0, len_q}) > 33'(MEM_DEPTH);

    assign tbl_wr_entry = '{valid: 1'b1, base: cursor_q, len: len_q};

    // NOTE: every signal assigned here gets its default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        count_d       = count_q;
        tmo_d         = tmo_q;
        pid_d         = pid_q;
        base_d        = base_q;
        len_d         = len_q;
        err_code_d    = err_code_q;
        tbl_clr       = 1'b0;
        tbl_wr        = 1'b0;
        mem_wr_data_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (clear_all) begin
                    cursor_d = '0;
                    tbl_clr  = 1'b1;
                end else if (start_load) begin
                    pid_d      = proc_id;
                    base_d     = hd_base;
                    len_d      = prog_len;
                    err_code_d = ERR_NONE;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (len_q == 16'd0) begin
                    err_code_d = ERR_ZERO;
                    state_d    = ST_FAIL;
                end else if (len_ovf) begin
                    err_code_d = ERR_OVF;
                    state_d    = ST_FAIL;
                end else begin
                    count_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (hd_valid) begin
                    mem_wr_data_d = hd_data;
                    state_d       = ST_WRITE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_code_d = ERR_TMO;
                    state_d    = ST_FAIL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WRITE: begin
                count_d = count_q + 16'd1;
                state_d = (count_q + 16'd1 == len_q) ? ST_FINISH : ST_REQ;
            end
            ST_FINISH: begin
                tbl_wr   = 1'b1;
                cursor_d = cursor_q + {16'b0, len_q};
                state_d  = ST_IDLE;
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs are decoded from the state being entered so
        // they are valid for the whole cycle spent in that state.
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_FINISH);
        error_d       = (state_d == ST_FAIL);
        hd_rd_en_d    = (state_d == ST_REQ);
        hd_addr_d     = hd_rd_en_d ? base_d + {16'b0, count_d} : '0;
        mem_wr_en_d   = (state_d == ST_WRITE);
        mem_wr_addr_d = mem_wr_en_d ? cursor_q + {16'b0, count_q} : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cursor_q      <= '0;
            count_q       <= '0;
            tmo_q         <= '0;
            pid_q         <= '0;
            base_q        <= '0;
            len_q         <= '0;
            err_code_q    <= ERR_NONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            hd_rd_en_q    <= 1'b0;
            hd_addr_q     <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            count_q       <= count_d;
            tmo_q         <= tmo_d;
            pid_q         <= pid_d;
            base_q        <= base_d;
            len_q         <= len_d;
            err_code_q    <= err_code_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            hd_rd_en_q    <= hd_rd_en_d;
            hd_addr_q     <= hd_addr_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    hd_program_loader_proc_table #(
        .MAX_PROCS (MAX_PROCS),
        .PROC_W    (PROC_W)
    ) u_proc_table (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (tbl_clr),
        .wr_en_i    (tbl_wr),
        .wr_idx_i   (pid_q),
        .wr_entry_i (tbl_wr_entry),
        .rd_idx_i   (sel_id),
        .rd_entry_o (tbl_rd_entry)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign hd_rd_en    = hd_rd_en_q;
    assign hd_addr     = hd_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign free_cursor = cursor_q;
    assign proc_valid  = tbl_rd_entry.valid;
    assign proc_base   = tbl_rd_entry.base;
    assign proc_len    = tbl_rd_entry.len;

endmodule

// File: tb/tb_hd_program_loader.sv
// -----------------------------------------------------------------------------
// tb_hd_program_loader
// Directed bench for hd_program_loader. An HD responder answers each read one
// cycle after hd_rd_en with a data pattern derived from the address; every
// read address, write address/data, pulse timing, cursor and table value is
// compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_hd_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_load = 1'b0;
    logic [2:0]  proc_id = '0;
    logic [31:0] hd_base = '0;
    logic [15:0] prog_len = '0;
    logic        clear_all = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] hd_addr;
    logic        hd_rd_en;
    logic [31:0] hd_data = '0;
    logic        hd_valid = 1'b0;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr, mem_wr_data, free_cursor;
    logic [2:0]  sel_id = '0;
    logic        proc_valid;
    logic [31:0] proc_base;
    logic [15:0] proc_len;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    hd_program_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start_load  (start_load),
        .proc_id     (proc_id),
        .hd_base     (hd_base),
        .prog_len    (prog_len),
        .clear_all   (clear_all),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .hd_addr     (hd_addr),
        .hd_rd_en    (hd_rd_en),
        .hd_data     (hd_data),
        .hd_valid    (hd_valid),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .free_cursor (free_cursor),
        .sel_id      (sel_id),
        .proc_valid  (proc_valid),
        .proc_base   (proc_base),
        .proc_len    (proc_len)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check_entry(input logic [2:0] pid, input logic v,
                               input logic [31:0] b, input logic [15:0] l);
        sel_id = pid;
        #1;
        check($sformatf("tbl%0d.valid", pid), {31'b0, proc_valid}, {31'b0, v});
        check($sformatf("tbl%0d.base", pid), proc_base, b);
        check($sformatf("tbl%0d.len", pid), {16'b0, proc_len}, {16'b0, l});
    endtask

    // Issues one load and plays the HD side. Cycle index n counts falling
    // edges after the edge that accepted the start (n=0 is the CHECK cycle).
    // Returns early after stop_wr writes when stop_wr > 0. If poke is set, a
    // conflicting start with other parameters is driven mid-load.
    task automatic run_load(input logic [2:0] pid, input logic [31:0] base,
                            input logic [15:0] len, input logic [31:0] cur0,
                            input bit respond, input int stop_wr, input bit poke,
                            output int rd_cnt, output int wr_cnt,
                            output int first_rd, output int done_at, output int err_at);
        bit pend;
        @(negedge clock);
        proc_id = pid; hd_base = base; prog_len = len; start_load = 1'b1;
        @(posedge clock);
        #1 start_load = 1'b0;
        rd_cnt = 0; wr_cnt = 0; first_rd = -1; done_at = -1; err_at = -1; pend = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            hd_valid = 1'b0;
            hd_data  = '0;
            start_load = 1'b0;
            if (pend && respond) begin
                hd_valid = 1'b1;
                hd_data  = pat(base + 32'(rd_cnt - 1));
            end
            pend = 1'b0;
            if (poke && n == 3) begin
                start_load = 1'b1; proc_id = 3'd0; hd_base = 32'd9999; prog_len = 16'd9;
            end
            if (hd_rd_en) begin
                if (first_rd < 0) first_rd = n;
                check("hd_addr", hd_addr, base + 32'(rd_cnt));
                rd_cnt++;
                pend = 1'b1;
            end
            if (mem_wr_en) begin
                check("mem_wr_addr", mem_wr_addr, cur0 + 32'(wr_cnt));
                check("mem_wr_data", mem_wr_data, pat(base + 32'(wr_cnt)));
                wr_cnt++;
                if (stop_wr > 0 && wr_cnt == stop_wr) return;
            end
            if (done)  begin done_at = n; break; end
            if (error) begin err_at  = n; break; end
        end
        hd_valid = 1'b0;
    endtask

    int rd_cnt, wr_cnt, first_rd, done_at, err_at;

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.cursor", free_cursor, 32'd0);
        check("rst.err_code", {30'b0, err_code}, 32'd0);
        check_entry(3'd2, 1'b0, 32'd0, 16'd0);
        reset = 1'b1;

        // 1: four-word load, 3 cycles per word
        run_load(3'd2, 32'd100, 16'd4, 32'd0, 1'b1, 0, 1'b0, rd_cnt, wr_cnt, first_rd, done_at, err_at);
        check("t1.reads", 32'(rd_cnt), 32'd4);
        check("t1.writes", 32'(wr_cnt), 32'd4);
        check("t1.done_latency", 32'(done_at - first_rd), 32'd12);
        check("t1.first_rd", 32'(first_rd), 32'd1);
        @(negedge clock);
        check("t1.cursor", free_cursor, 32'd4);
        check("t1.busy", {31'b0, busy}, 32'd0);
        check("t1.done_pulse", {31'b0, done}, 32'd0);
        check_entry(3'd2, 1'b1, 32'd0, 16'd4);

        // 2: second load lands after the first
        run_load(3'd5, 32'd500, 16'd3, 32'd4, 1'b1, 0, 1'b0, rd_cnt, wr_cnt, first_rd, done_at, err_at);
        check("t2.writes", 32'(wr_cnt), 32'd3);
        check("t2.done", 32'(done_at), 32'd10);
        @(negedge clock);
        check("t2.cursor", free_cursor, 32'd7);
        check_entry(3'd5, 1'b1, 32'd4, 16'd3);
        check_entry(3'd2, 1'b1, 32'd0, 16'd4);

        // 6a: start while busy is ignored; then zero length
        run_load(3'd6, 32'd700, 16'd2, 32'd7, 1'b1, 0, 1'b1, rd_cnt, wr_cnt, first_rd, done_at, err_at);
        check("t6.writes", 32'(wr_cnt), 32'd2);
        check("t6.done", 32'(done_at), 32'd7);
        @(negedge clock);
        check("t6.cursor", free_cursor, 32'd9);
        check("t6.busy_after", {31'b0, busy}, 32'd0);
        check_entry(3'd6, 1'b1, 32'd7, 16'd2);
        check_entry(3'd0, 1'b0, 32'd0, 16'd0);
        run_load(3'd3, 32'd50, 16'd0, 32'd9, 1'b1, 0, 1'b0, rd_cnt, wr_cnt, first_rd, done_at, err_at);
        check("t6.zero_err_at", 32'(err_at), 32'd1);
        check("t6.zero_code", {30'b0, err_code}, 32'd3);
        check("t6.zero_reads", 32'(rd_cnt), 32'd0);
        @(negedge clock);
        check("t6.zero_code_hold", {30'b0, err_code}, 32'd3);
        check("t6.zero_err_pulse", {31'b0, error}, 32'd0);
        check("t6.zero_cursor", free_cursor, 32'd9);

        // 5: reset after two words of a four-word load
        run_load(3'd1, 32'd800, 16'd4, 32'd9, 1'b1, 2, 1'b0, rd_cnt, wr_cnt, first_rd, done_at, err_at);
        check("t5.writes", 32'(wr_cnt), 32'd2);
        reset = 1'b0;
        #1;
        check("t5.busy", {31'b0, busy}, 32'd0);
        check("t5.mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
        check("t5.mem_wr_addr", mem_wr_addr, 32'd0);
        check("t5.mem_wr_data", mem_wr_data, 32'd0);
        check("t5.hd_rd_en", {31'b0, hd_rd_en}, 32'd0);
        check("t5.hd_addr", hd_addr, 32'd0);
        check("t5.err_code", {30'b0, err_code}, 32'd0);
        check("t5.cursor", free_cursor, 32'd0);
        for (int i = 0; i < 8; i++) check_entry(3'(i), 1'b0, 32'd0, 16'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t5.idle", {31'b0, busy}, 32'd0);

        // Fill to 198 words
        run_load(3'd7, 32'd1000, 16'd198, 32'd0, 1'b1, 0, 1'b0, rd_cnt, wr_cnt, first_rd, done_at, err_at);
        check("fill.writes", 32'(wr_cnt), 32'd198);
        @(negedge clock);
        check("fill.cursor", free_cursor, 32'd198);

        // 3: 198 + 5 > 201 overflows
        run_load(3'd3, 32'd60, 16'd5, 32'd198, 1'b1, 0, 1'b0, rd_cnt, wr_cnt, first_rd, done_at, err_at);
        check("t3.err_at", 32'(err_at), 32'd1);
        check("t3.code", {30'b0, err_code}, 32'd1);
        check("t3.reads", 32'(rd_cnt), 32'd0);
        check("t3.writes", 32'(wr_cnt), 32'd0);
        @(negedge clock);
        check("t3.cursor", free_cursor, 32'd198);
        check_entry(3'd3, 1'b0, 32'd0, 16'd0);

        // 4: no hd_valid -> timeout after 64 WAIT cycles
        run_load(3'd1, 32'd2000, 16'd3, 32'd198, 1'b0, 0, 1'b0, rd_cnt, wr_cnt, first_rd, done_at, err_at);
        check("t4.reads", 32'(rd_cnt), 32'd1);
        check("t4.err_latency", 32'(err_at - first_rd), 32'd65);
        check("t4.code", {30'b0, err_code}, 32'd2);
        check("t4.writes", 32'(wr_cnt), 32'd0);
        @(negedge clock);
        check("t4.cursor", free_cursor, 32'd198);
        check_entry(3'd1, 1'b0, 32'd0, 16'd0);

        // Boundary: 198 + 3 == 201 fits exactly, and clears err_code
        run_load(3'd4, 32'd3000, 16'd3, 32'd198, 1'b1, 0, 1'b0, rd_cnt, wr_cnt, first_rd, done_at, err_at);
        check("edge.done", 32'(done_at), 32'd10);
        check("edge.code", {30'b0, err_code}, 32'd0);
        @(negedge clock);
        check("edge.cursor", free_cursor, 32'd201);
        check_entry(3'd4, 1'b1, 32'd198, 16'd3);

        // 6b: clear_all beats a simultaneous start
        @(negedge clock);
        clear_all = 1'b1; start_load = 1'b1; proc_id = 3'd2; prog_len = 16'd1;
        @(posedge clock);
        #1 clear_all = 1'b0; start_load = 1'b0;
        @(negedge clock);
        check("t6.clr_busy", {31'b0, busy}, 32'd0);
        check("t6.clr_cursor", free_cursor, 32'd0);
        for (int i = 0; i < 8; i++) check_entry(3'(i), 1'b0, 32'd0, 16'd0);
        repeat (2) @(negedge clock);
        check("t6.clr_no_start", {31'b0, busy | hd_rd_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
